// File: rtl/shaper_ctrl_if.sv
// Configuration request bus and event output bus of the shaper controller.
// The master side is the readout/consumer. The slave side is shaper_ctrl.
interface shaper_ctrl_if #(
   parameter int KW               = 7,
   parameter int SIZE_FILTER_DATA = 16
);
   logic                               cfg_valid;
   logic                               cfg_ready;
   logic [KW-1:0]                      cfg_k;
   logic [KW-1:0]                      cfg_l;
   logic [15:0]                        cfg_m;
   logic signed [SIZE_FILTER_DATA-1:0] cfg_thr;
   logic                               cfg_err;
   logic                               ev_valid;
   logic                               ev_ready;
   logic signed [SIZE_FILTER_DATA-1:0] ev_peak;
   logic [15:0]                        ev_time;

   modport master (
      output cfg_valid, cfg_k, cfg_l, cfg_m, cfg_thr, ev_ready,
      input  cfg_ready, cfg_err, ev_valid, ev_peak, ev_time
   );

   modport slave (
      input  cfg_valid, cfg_k, cfg_l, cfg_m, cfg_thr, ev_ready,
      output cfg_ready, cfg_err, ev_valid, ev_peak, ev_time
   );
endinterface

// File: rtl/shaper_ctrl.sv
// Sequencing and event controller for the trapezoidal shaping filter.
// The controller owns the applied k/l/M configuration and the filter reset.
// It runs a flush/settle sequence after reset and after every accepted configuration.
// When armed, it turns each threshold-crossing pulse into one {peak, timestamp} event.
// The event goes out through a single-entry buffer. Events are dropped when that buffer is full.
module shaper_ctrl #(
   parameter int N                = 64,
   parameter int PIPE             = 6,
   parameter int SIZE_FILTER_DATA = 16,
   parameter int KW               = 7,
   parameter int DEF_K            = 8,
   parameter int DEF_L            = 16,
   parameter int DEF_M            = 100,
   parameter int DEF_THR          = 64
) (
   input  logic                               clk,
   input  logic                               reset,
   shaper_ctrl_if.slave                       bus,
   output logic                               flt_reset_n,
   output logic [KW-1:0]                      flt_k,
   output logic [KW-1:0]                      flt_l,
   output logic [15:0]                        flt_m,
   input  logic signed [SIZE_FILTER_DATA-1:0] flt_data,
   output logic                               active,
   output logic [7:0]                         drop_cnt
);
   localparam int SW = SIZE_FILTER_DATA;
   localparam int SETTLE_CYC = N + PIPE;
   localparam int CW = $clog2(SETTLE_CYC + 1);
   localparam logic [KW:0] N_LIM = (KW+1)'(N);

   typedef enum logic [1:0] {
      FLUSH  = 2'd0,
      SETTLE = 2'd1,
      ARMED  = 2'd2,
      PEAK   = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [KW-1:0]        k_q, k_d, l_q, l_d;
   logic [15:0]          m_q, m_d;
   logic signed [SW-1:0] thr_q, thr_d;
   logic                 cfg_err_q, cfg_err_d;
   logic                 cfg_ready_q, cfg_ready_d;
   logic                 flt_rst_n_q, flt_rst_n_d;
   logic                 active_q, active_d;
   logic                 ev_valid_q, ev_valid_d;
   logic signed [SW-1:0] ev_peak_q, ev_peak_d;
   logic [15:0]          ev_time_q, ev_time_d;
   logic [7:0]           drop_q, drop_d;
   logic [15:0]          ts_q, ts_d;
   logic signed [SW-1:0] max_q, max_d;
   logic [15:0]          tmax_q, tmax_d;
   logic                 cfg_fire_s;
   logic                 emit_s;

   // A request is usable only if both windows are non-empty and they fit in the delay line.
   function automatic logic cfg_ok(input logic [KW-1:0] k, input logic [KW-1:0] l);
      logic [KW:0] sum;
      sum = {1'b0, k} + {1'b0, l};
      return (k != '0) && (l != '0) && (sum <= N_LIM);
   endfunction

   // This block computes the next state, the sequencing counter, the pulse tracker, the configuration and the event buffer.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      k_d       = k_q;
      l_d       = l_q;
      m_d       = m_q;
      thr_d     = thr_q;
      cfg_err_d = cfg_err_q;
      ev_valid_d = ev_valid_q;
      ev_peak_d = ev_peak_q;
      ev_time_d = ev_time_q;
      drop_d    = drop_q;
      max_d     = max_q;
      tmax_d    = tmax_q;
      ts_d      = ts_q + 16'd1;
      emit_s    = 1'b0;
      cfg_fire_s = bus.cfg_valid && cfg_ready_q;

      case (state_q)
         FLUSH: begin
            if (cnt_q == CW'(1)) begin
               state_d = SETTLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         SETTLE: begin
            if (cnt_q == CW'(SETTLE_CYC - 1)) begin
               state_d = ARMED;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ARMED: begin
            if (flt_data > thr_q) begin
               state_d = PEAK;
               max_d   = flt_data;
               tmax_d  = ts_q;
            end else begin
               state_d = ARMED;
            end
         end
         PEAK: begin
            if (flt_data <= thr_q) begin
               emit_s  = 1'b1;
               state_d = ARMED;
            end else if (flt_data > max_q) begin
               max_d  = flt_data;
               tmax_d = ts_q;
            end else begin
               state_d = PEAK;
            end
         end
         default: begin
            state_d = FLUSH;
            cnt_d   = '0;
         end
      endcase

      // An accepted valid request wins over pulse tracking and aborts any pulse in flight.
      if (cfg_fire_s) begin
         if (cfg_ok(bus.cfg_k, bus.cfg_l)) begin
            k_d       = bus.cfg_k;
            l_d       = bus.cfg_l;
            m_d       = bus.cfg_m;
            thr_d     = bus.cfg_thr;
            cfg_err_d = 1'b0;
            state_d   = FLUSH;
            cnt_d     = '0;
            emit_s    = 1'b0;
         end else begin
            cfg_err_d = 1'b1;
         end
      end else begin
         cfg_err_d = cfg_err_q;
      end

      if (ev_valid_q && bus.ev_ready) begin
         ev_valid_d = 1'b0;
      end else begin
         ev_valid_d = ev_valid_q;
      end

      if (emit_s) begin
         if (!ev_valid_q || bus.ev_ready) begin
            ev_valid_d = 1'b1;
            ev_peak_d  = max_q;
            ev_time_d  = tmax_q;
         end else if (drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
         end else begin
            drop_d = drop_q;
         end
      end else begin
         drop_d = drop_q;
      end

      flt_rst_n_d = (state_d != FLUSH);
      cfg_ready_d = (state_d != FLUSH);
      active_d    = (state_d == ARMED) || (state_d == PEAK);
   end

   // Register update. Synchronous reset loads the default configuration and restarts the flush.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= FLUSH;
         cnt_q       <= '0;
         k_q         <= KW'(DEF_K);
         l_q         <= KW'(DEF_L);
         m_q         <= 16'(DEF_M);
         thr_q       <= SW'(DEF_THR);
         cfg_err_q   <= 1'b0;
         cfg_ready_q <= 1'b0;
         flt_rst_n_q <= 1'b0;
         active_q    <= 1'b0;
         ev_valid_q  <= 1'b0;
         ev_peak_q   <= '0;
         ev_time_q   <= 16'd0;
         drop_q      <= 8'd0;
         ts_q        <= 16'd0;
         max_q       <= '0;
         tmax_q      <= 16'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         k_q         <= k_d;
         l_q         <= l_d;
         m_q         <= m_d;
         thr_q       <= thr_d;
         cfg_err_q   <= cfg_err_d;
         cfg_ready_q <= cfg_ready_d;
         flt_rst_n_q <= flt_rst_n_d;
         active_q    <= active_d;
         ev_valid_q  <= ev_valid_d;
         ev_peak_q   <= ev_peak_d;
         ev_time_q   <= ev_time_d;
         drop_q      <= drop_d;
         ts_q        <= ts_d;
         max_q       <= max_d;
         tmax_q      <= tmax_d;
      end
   end

   assign bus.cfg_ready = cfg_ready_q;
   assign bus.cfg_err   = cfg_err_q;
   assign bus.ev_valid  = ev_valid_q;
   assign bus.ev_peak   = ev_peak_q;
   assign bus.ev_time   = ev_time_q;
   assign flt_reset_n   = flt_rst_n_q;
   assign flt_k         = k_q;
   assign flt_l         = l_q;
   assign flt_m         = m_q;
   assign active        = active_q;
   assign drop_cnt      = drop_q;
endmodule
